// File: rtl/arts_div_pkg.sv
// Shared constants, FSM states and shift helper for the ARTS approximate divider.
package arts_div_pkg;

  localparam int N    = 32;
  localparam int W    = 8;
  localparam int KW   = 2;
  localparam int SEGS = N / W;
  localparam int CW   = $clog2(2 * W);
  localparam int SW   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEG,
    DIV,
    SCALE,
    DONE
  } state_t;

  typedef logic signed [SW-1:0] shamt_t;

  // Window quotient scale: W*(Ka-Kb) - W, ranges -N..+2W.
  function automatic shamt_t shift_amount(input logic [KW-1:0] ka, input logic [KW-1:0] kb);
    return shamt_t'(W * (int'(ka) - int'(kb)) - W);
  endfunction

endpackage

// File: rtl/arts_seg_detect.sv
// Leading W-bit segment detection: index, 2W-bit window and leading segment.
module arts_seg_detect
  import arts_div_pkg::*;
(
  input  logic [N-1:0]   x,
  output logic [KW-1:0]  k,
  output logic [2*W-1:0] win,
  output logic [W-1:0]   lead
);

  logic [W-1:0]    seg [SEGS];
  logic [SEGS-1:0] nz;

  for (genvar gi = 0; gi < SEGS; gi++) begin : g_seg
    assign seg[gi] = x[gi*W +: W];
    assign nz[gi]  = |seg[gi];
  end

  always_comb begin
    k = '0;
    for (int i = 0; i < SEGS; i++) begin
      if (nz[i]) k = KW'(i);
    end
  end

  always_comb begin
    lead = seg[k];
    if (k == '0) win = {seg[0], {W{1'b0}}};
    else         win = {seg[k], seg[k - KW'(1)]};
  end

endmodule

// File: rtl/arts_div_n32_w8.sv
// Sequential approximate unsigned divider: segment windowing, bit-serial
// restoring divide on the window, then rescale by the segment offsets.
module arts_div_n32_w8
  import arts_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] q,
  output logic         dbz
);

  state_t         state_reg, state_next;
  logic [N-1:0]   a_reg, a_next;
  logic [N-1:0]   b_reg, b_next;
  logic [2*W-1:0] wd_reg, wd_next;
  logic [W-1:0]   ds_reg, ds_next;
  logic [W:0]     rem_reg, rem_next;
  logic [2*W-1:0] qw_reg, qw_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  shamt_t         sh_reg, sh_next;
  logic [N-1:0]   q_reg, q_next;
  logic           dbz_reg, dbz_next;

  logic [KW-1:0]  ka, kb;
  logic [2*W-1:0] a_win, b_win;
  logic [W-1:0]   a_lead, b_lead;
  logic [W:0]     rem_shift;
  logic [W:0]     ds_ext;
  logic [N-1:0]   qw_ext;
  logic [SW-1:0]  sh_mag;
  logic           a_zero, b_zero;

  arts_seg_detect u_seg_a (.x(a_reg), .k(ka), .win(a_win), .lead(a_lead));
  arts_seg_detect u_seg_b (.x(b_reg), .k(kb), .win(b_win), .lead(b_lead));

  // Leading segment / window are nonzero exactly when the operand is nonzero.
  assign a_zero    = (a_lead == '0);
  assign b_zero    = (b_win == '0);
  assign rem_shift = (rem_reg << 1) | {{W{1'b0}}, wd_reg[2*W-1]};
  assign ds_ext    = {1'b0, ds_reg};
  assign qw_ext    = {{(N-2*W){1'b0}}, qw_reg};
  assign sh_mag    = sh_reg[SW-1] ? SW'(-sh_reg) : SW'(sh_reg);

  assign q   = q_reg;
  assign dbz = dbz_reg;

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    wd_next    = wd_reg;
    ds_next    = ds_reg;
    rem_next   = rem_reg;
    qw_next    = qw_reg;
    cnt_next   = cnt_reg;
    sh_next    = sh_reg;
    q_next     = q_reg;
    dbz_next   = dbz_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          state_next = SEG;
        end
      end
      SEG: begin
        wd_next  = a_win;
        ds_next  = b_lead;
        sh_next  = shift_amount(ka, kb);
        rem_next = '0;
        qw_next  = '0;
        cnt_next = CW'(2 * W - 1);
        if (b_zero) begin
          q_next     = '1;
          dbz_next   = 1'b1;
          state_next = DONE;
        end else if (a_zero) begin
          q_next     = '0;
          dbz_next   = 1'b0;
          state_next = DONE;
        end else begin
          dbz_next   = 1'b0;
          state_next = DIV;
        end
      end
      DIV: begin
        wd_next  = wd_reg << 1;
        cnt_next = cnt_reg - CW'(1);
        if (rem_shift >= ds_ext) begin
          rem_next = rem_shift - ds_ext;
          qw_next  = {qw_reg[2*W-2:0], 1'b1};
        end else begin
          rem_next = rem_shift;
          qw_next  = {qw_reg[2*W-2:0], 1'b0};
        end
        if (cnt_reg == '0) state_next = SCALE;
      end
      SCALE: begin
        // Negative shifts drop the bits that fall below bit 0.
        q_next     = sh_reg[SW-1] ? (qw_ext >> sh_mag) : (qw_ext << sh_mag);
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      wd_reg    <= '0;
      ds_reg    <= '0;
      rem_reg   <= '0;
      qw_reg    <= '0;
      cnt_reg   <= '0;
      sh_reg    <= '0;
      q_reg     <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      wd_reg    <= wd_next;
      ds_reg    <= ds_next;
      rem_reg   <= rem_next;
      qw_reg    <= qw_next;
      cnt_reg   <= cnt_next;
      sh_reg    <= sh_next;
      q_reg     <= q_next;
      dbz_reg   <= dbz_next;
    end
  end

endmodule

// File: tb/tb_arts_div_n32_w8.sv
// Self-checking bench for arts_div_n32_w8: directed cases, backpressure,
// mid-divide reset and randomized operands against an arithmetic model.
module tb_arts_div_n32_w8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic        dbz;

  int total = 0;
  int bad   = 0;

  arts_div_n32_w8 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {dbz, q} from the segment-window approximation in plain arithmetic.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    int ka, kb, s;
    longint unsigned xv, yv, wd, ds, qw, r;
    if (y == 0) return {1'b1, 32'hFFFF_FFFF};
    if (x == 0) return {1'b0, 32'h0};
    xv = x;
    yv = y;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 4; i++) begin
      if (((xv >> (8 * i)) & 64'hFF) != 0) ka = i;
      if (((yv >> (8 * i)) & 64'hFF) != 0) kb = i;
    end
    if (ka == 0) wd = (xv & 64'hFF) << 8;
    else         wd = (xv >> (8 * (ka - 1))) & 64'hFFFF;
    ds = (yv >> (8 * kb)) & 64'hFF;
    qw = wd / ds;
    s  = 8 * (ka - kb) - 8;
    if (s >= 0) r = qw << s;
    else        r = qw >> (-s);
    return {1'b0, r[31:0]};
  endfunction

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] eq, input logic ed, input int elat, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk); #1;
    in_valid = (hold > 0);
    a = $urandom;
    b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk("busy_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("q", q, eq);
    chk("dbz", 32'(dbz), 32'(ed));
    chk("latency", 32'(lat), 32'(elat));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      chk("hold_q", q, eq);
      chk("hold_dbz", 32'(dbz), 32'(ed));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
    $display("op a=%h b=%h q=%h dbz=%0d lat=%0d exp_q=%h", ta, tb_v, q, dbz, lat, eq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ta, tbv;
    logic [32:0] r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;

    do_op(32'd1000, 32'd10, 32'd100, 1'b0, 19, 0);
    do_op(32'h1234_5678, 32'h0000_1000, 32'h0001_2300, 1'b0, 19, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_0000, 1'b0, 19, 0);
    do_op(32'd5, 32'h0100_0000, 32'd0, 1'b0, 19, 0);
    do_op(32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, 0);
    do_op(32'd0, 32'd9, 32'd0, 1'b0, 2, 0);
    do_op(32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 2, 0);
    do_op(32'h1234_5678, 32'h0000_1000, 32'h0001_2300, 1'b0, 19, 10);

    // Abort an operation partway through the divide.
    in_valid = 1'b1;
    a = 32'h00AB_CDEF;
    b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_q", q, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(32'd1000, 32'd10, 32'd100, 1'b0, 19, 0);

    for (int i = 0; i < 40; i++) begin
      ta  = $urandom >> $urandom_range(0, 31);
      tbv = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      r   = model(ta, tbv);
      do_op(ta, tbv, r[31:0], r[32], (ta == 0 || tbv == 0) ? 2 : 19, (i % 13 == 5) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
